// File: rtl/commit_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : commit_wb_arbiter
// Purpose  : Round-robin arbiter that merges NUM_REQS commit sources into a
//            single registered writeback slot. Commits with wb=0 retire
//            immediately and are counted in nowb_count. Multi-beat commits
//            keep priority until their eop beat is accepted.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            commit_*_in            - per-source commit payload + valid
//            commit_ready_out       - per-source accept (one-hot or zero)
//            wb_valid / wb_ready    - writeback handshake
//            wb_*                   - registered writeback payload
//            nowb_count             - retired wb=0 commits (wraps at 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module commit_wb_arbiter #(
  parameter int NUM_REQS    = 3,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQS-1:0]                       commit_valid_in,
  output logic [NUM_REQS-1:0]                       commit_ready_out,
  input  logic [NUM_REQS-1:0][UUID_BITS-1:0]        commit_uuid_in,
  input  logic [NUM_REQS-1:0][NW_BITS-1:0]          commit_wid_in,
  input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]      commit_tmask_in,
  input  logic [NUM_REQS-1:0][31:0]                 commit_PC_in,
  input  logic [NUM_REQS-1:0][NR_BITS-1:0]          commit_rd_in,
  input  logic [NUM_REQS-1:0]                       commit_wb_in,
  input  logic [NUM_REQS-1:0]                       commit_eop_in,
  input  logic [NUM_REQS-1:0][NUM_THREADS*32-1:0]   commit_data_in,
  output logic                                      wb_valid,
  input  logic                                      wb_ready,
  output logic [UUID_BITS-1:0]                      wb_uuid,
  output logic [NW_BITS-1:0]                        wb_wid,
  output logic [NUM_THREADS-1:0]                    wb_tmask,
  output logic [31:0]                               wb_PC,
  output logic [NR_BITS-1:0]                        wb_rd,
  output logic                                      wb_eop,
  output logic [NUM_THREADS*32-1:0]                 wb_data,
  output logic [31:0]                               nowb_count
);

  localparam int                 C_PTR_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [C_PTR_W:0]   C_NUM_REQS  = (C_PTR_W+1)'(NUM_REQS);
  localparam logic [C_PTR_W-1:0] C_LAST_IDX  = C_PTR_W'(NUM_REQS - 1);

  // control state
  logic [C_PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [31:0]              nowb_count_q, nowb_count_d;

  // output slot payload (no reset needed; qualified by wb_valid_q)
  logic [UUID_BITS-1:0]     wb_uuid_q, wb_uuid_d;
  logic [NW_BITS-1:0]       wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0]   wb_tmask_q, wb_tmask_d;
  logic [31:0]              wb_PC_q, wb_PC_d;
  logic [NR_BITS-1:0]       wb_rd_q, wb_rd_d;
  logic                     wb_eop_q, wb_eop_d;
  logic [NUM_THREADS*32-1:0] wb_data_q, wb_data_d;

  logic                     w_found;
  logic [C_PTR_W-1:0]       w_sel;
  logic [C_PTR_W:0]         w_cand;
  logic                     w_out_ready;
  logic                     w_sel_wb;
  logic                     w_grant;

  // Priority scan starting at rr_ptr_q. The candidate index is kept one bit
  // wider so rr_ptr + i cannot overflow before the modulo correction.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_cand = {1'b0, rr_ptr_q} + (C_PTR_W+1)'(i);
      if (w_cand >= C_NUM_REQS) begin
        w_cand = w_cand - C_NUM_REQS;
      end
      if (!w_found && commit_valid_in[w_cand[C_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[C_PTR_W-1:0];
      end
    end
  end

  // Only the highest-priority valid source may be granted. If it needs the
  // slot and the slot is blocked, nothing is granted: lower-priority wb=0
  // sources must not overtake it.
  always_comb begin
    w_out_ready = ~wb_valid_q | wb_ready;
    w_sel_wb    = commit_wb_in[w_sel];
    w_grant     = w_found & ~reset & (~w_sel_wb | w_out_ready);

    commit_ready_out = '0;
    if (w_grant) begin
      commit_ready_out[w_sel] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    nowb_count_d = nowb_count_q;
    wb_valid_d   = wb_valid_q;
    wb_uuid_d    = wb_uuid_q;
    wb_wid_d     = wb_wid_q;
    wb_tmask_d   = wb_tmask_q;
    wb_PC_d      = wb_PC_q;
    wb_rd_d      = wb_rd_q;
    wb_eop_d     = wb_eop_q;
    wb_data_d    = wb_data_q;

    // Pointer moves past a source only once its final beat is taken, so a
    // multi-beat source stays at the head of the scan.
    if (w_grant && commit_eop_in[w_sel]) begin
      rr_ptr_d = (w_sel == C_LAST_IDX) ? '0 : w_sel + C_PTR_W'(1);
    end

    if (w_grant && !w_sel_wb) begin
      nowb_count_d = nowb_count_q + 32'd1;
    end

    if (w_grant && w_sel_wb) begin
      wb_valid_d = 1'b1;
      wb_uuid_d  = commit_uuid_in[w_sel];
      wb_wid_d   = commit_wid_in[w_sel];
      wb_tmask_d = commit_tmask_in[w_sel];
      wb_PC_d    = commit_PC_in[w_sel];
      wb_rd_d    = commit_rd_in[w_sel];
      wb_eop_d   = commit_eop_in[w_sel];
      wb_data_d  = commit_data_in[w_sel];
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      wb_valid_q   <= 1'b0;
      nowb_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wb_valid_q   <= wb_valid_d;
      nowb_count_q <= nowb_count_d;
    end
  end

  always_ff @(posedge clk) begin
    wb_uuid_q  <= wb_uuid_d;
    wb_wid_q   <= wb_wid_d;
    wb_tmask_q <= wb_tmask_d;
    wb_PC_q    <= wb_PC_d;
    wb_rd_q    <= wb_rd_d;
    wb_eop_q   <= wb_eop_d;
    wb_data_q  <= wb_data_d;
  end

  assign wb_valid   = wb_valid_q;
  assign wb_uuid    = wb_uuid_q;
  assign wb_wid     = wb_wid_q;
  assign wb_tmask   = wb_tmask_q;
  assign wb_PC      = wb_PC_q;
  assign wb_rd      = wb_rd_q;
  assign wb_eop     = wb_eop_q;
  assign wb_data    = wb_data_q;
  assign nowb_count = nowb_count_q;

endmodule
`default_nettype wire
